// File: rtl/mrd_mem_pkt.sv
// Shared constants and state type for the mixed-radix DFT memory top.
// Packet buffer sizing lives here alongside the buffer FSM encoding.
package mrd_mem_pkt;

  localparam int PKTBUF_DEPTH = 2048;
  localparam int wPKTBUF_ADDR = 11;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WAIT,
    DRAIN
  } pktbuf_state_t;

endpackage

// File: rtl/mrd_pktbuf_ram.sv
// Behavioral simple dual-port RAM with registered read data.
// Swappable for the vendor RAM IP.
module mrd_pktbuf_ram #(
  parameter int DEPTH = 2048,
  parameter int wADDR = 11,
  parameter int wD    = 36
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [wADDR-1:0] i_waddr,
  input  logic [wD-1:0]    i_wdata,
  input  logic             i_re,
  input  logic [wADDR-1:0] i_raddr,
  output logic [wD-1:0]    o_q
);

  logic [wD-1:0] r_mem [DEPTH];

  // Same-address read and write returns the old word.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_q <= r_mem[i_raddr];
  end

endmodule

// File: rtl/mrd_sink_pkt_buf.sv
// Single-packet buffer ahead of the DFT memory top's Sink stage.
// Define MRD_PKTBUF_LEN_CHK_EN to drop packets whose length != dftpts.
module mrd_sink_pkt_buf
  import mrd_mem_pkt::*;
#(
  parameter int DEPTH = PKTBUF_DEPTH,
  parameter int wADDR = wPKTBUF_ADDR,
  parameter int wDATA = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [wDATA-1:0] in_real,
  input  logic [wDATA-1:0] in_imag,
  input  logic [5:0]       in_size,
  input  logic [11:0]      in_dftpts,
  output logic             in_ready,
  input  logic             sink_ready,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic [wDATA-1:0] out_real,
  output logic [wDATA-1:0] out_imag,
  output logic [5:0]       out_size,
  output logic [11:0]      out_dftpts,
  output logic             err_ovf,
  output logic             err_len
);

  localparam logic [wADDR:0] LP_DEPTH = (wADDR+1)'(DEPTH);

  pktbuf_state_t r_state, w_nxt;

  logic [wADDR:0]   r_wcnt, w_wcnt_nxt;
  logic [wADDR:0]   r_len, w_len_nxt;
  logic [wADDR:0]   r_rcnt, w_rcnt_nxt;
  logic [5:0]       r_size;
  logic [11:0]      r_dftpts;
  logic             w_we, w_re, w_latch;
  logic             w_fin, w_ovf, w_lenerr, w_drain_go;
  logic [wADDR-1:0] w_waddr;
  logic [2*wDATA-1:0] w_q;
  logic             w_last;
  logic             r_v1, r_sop1, r_eop1;

  assign in_ready = !rst && (r_state == IDLE || r_state == FILL);
  assign w_last   = (r_rcnt == r_len - 1'b1);

`ifdef MRD_PKTBUF_LEN_CHK_EN
  logic [11:0] w_chk_pts;
  logic        r_err_len;
  assign w_chk_pts = w_latch ? in_dftpts : r_dftpts;
  assign err_len   = r_err_len;
`else
  assign err_len = 1'b0;
`endif

  always_comb begin
    w_nxt      = r_state;
    w_we       = 1'b0;
    w_re       = 1'b0;
    w_latch    = 1'b0;
    w_fin      = 1'b0;
    w_ovf      = 1'b0;
    w_lenerr   = 1'b0;
    w_drain_go = 1'b0;
    w_waddr    = r_wcnt[wADDR-1:0];
    w_wcnt_nxt = r_wcnt;
    w_len_nxt  = r_len;
    w_rcnt_nxt = r_rcnt;
    unique case (r_state)
      IDLE: begin
        if (in_valid && in_sop && !rst) begin
          w_we       = 1'b1;
          w_waddr    = '0;
          w_wcnt_nxt = 1;
          w_latch    = 1'b1;
          w_nxt      = FILL;
          if (in_eop) begin
            w_fin     = 1'b1;
            w_len_nxt = 1;
          end
        end
      end
      FILL: begin
        if (in_valid) begin
          if (in_sop) begin
            w_we       = 1'b1;
            w_waddr    = '0;
            w_wcnt_nxt = 1;
            w_latch    = 1'b1;
            if (in_eop) begin
              w_fin     = 1'b1;
              w_len_nxt = 1;
            end
          end else if (r_wcnt == LP_DEPTH) begin
            w_ovf      = 1'b1;
            w_wcnt_nxt = '0;
            w_nxt      = IDLE;
          end else begin
            w_we       = 1'b1;
            w_wcnt_nxt = r_wcnt + 1'b1;
            if (in_eop) begin
              w_fin     = 1'b1;
              w_len_nxt = r_wcnt + 1'b1;
            end
          end
        end
      end
      WAIT: begin
        if (sink_ready) begin
          w_nxt      = DRAIN;
          w_rcnt_nxt = '0;
          w_drain_go = 1'b1;
        end
      end
      DRAIN: begin
        w_re = 1'b1;
        if (w_last) w_nxt = IDLE;
        else w_rcnt_nxt = r_rcnt + 1'b1;
      end
    endcase
    if (w_fin) begin
      w_nxt = WAIT;
`ifdef MRD_PKTBUF_LEN_CHK_EN
      if (12'(w_len_nxt) != w_chk_pts) begin
        w_lenerr = 1'b1;
        w_nxt    = IDLE;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_wcnt   <= '0;
      r_len    <= '0;
      r_rcnt   <= '0;
      r_size   <= '0;
      r_dftpts <= '0;
      err_ovf  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_len   <= w_len_nxt;
      r_rcnt  <= w_rcnt_nxt;
      err_ovf <= w_ovf;
      if (w_latch) begin
        r_size   <= in_size;
        r_dftpts <= in_dftpts;
      end
    end
  end

`ifdef MRD_PKTBUF_LEN_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err_len <= 1'b0;
    else     r_err_len <= w_lenerr;
  end
`endif

  mrd_pktbuf_ram #(
    .DEPTH (DEPTH),
    .wADDR (wADDR),
    .wD    (2*wDATA)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata ({in_real, in_imag}),
    .i_re    (w_re),
    .i_raddr (r_rcnt[wADDR-1:0]),
    .o_q     (w_q)
  );

  // Stage 1 tracks RAM q; stage 2 is the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1       <= 1'b0;
      r_sop1     <= 1'b0;
      r_eop1     <= 1'b0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_real   <= '0;
      out_imag   <= '0;
      out_size   <= '0;
      out_dftpts <= '0;
    end else begin
      r_v1      <= w_re;
      r_sop1    <= w_re && (r_rcnt == '0);
      r_eop1    <= w_re && w_last;
      out_valid <= r_v1;
      out_sop   <= r_sop1;
      out_eop   <= r_eop1;
      if (r_v1) {out_real, out_imag} <= w_q;
      if (w_drain_go) begin
        out_size   <= r_size;
        out_dftpts <= r_dftpts;
      end
    end
  end

endmodule

// File: tb/tb_mrd_sink_pkt_buf.sv
// Self-checking bench for mrd_sink_pkt_buf: packet-level model plus
// directed packets with hand-computed expectations.
module tb_mrd_sink_pkt_buf;

  localparam int DEPTH = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [17:0] in_real = '0, in_imag = '0;
  logic [5:0]  in_size = '0;
  logic [11:0] in_dftpts = '0;
  logic        in_ready;
  logic        sink_ready = 1'b0;
  logic        out_valid, out_sop, out_eop;
  logic [17:0] out_real, out_imag;
  logic [5:0]  out_size;
  logic [11:0] out_dftpts;
  logic        err_ovf, err_len;

  mrd_sink_pkt_buf dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_real(in_real), .in_imag(in_imag),
    .in_size(in_size), .in_dftpts(in_dftpts),
    .in_ready(in_ready), .sink_ready(sink_ready),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_real(out_real), .out_imag(out_imag),
    .out_size(out_size), .out_dftpts(out_dftpts),
    .err_ovf(err_ovf), .err_len(err_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [17:0] re;
    logic [17:0] im;
  } smp_t;

  // Packet-level model
  int   cyc = 0;
  smp_t m_cur[$], m_pk[$], m_out[$];
  bit   m_col, m_pend, m_ovf, m_len;
  int   m_drain, m_ostart, m_olen;
  logic [5:0]  m_sz, m_psz, m_osz;
  logic [11:0] m_dp, m_pdp, m_odp;

  always @(posedge clk) begin
    smp_t s;
    bit rdy;
    cyc++;
    m_ovf = 0;
    m_len = 0;
    if (rst) begin
      m_cur.delete(); m_pk.delete();
      m_col = 0; m_pend = 0; m_drain = 0; m_olen = 0;
    end else begin
      rdy = !m_pend && m_drain == 0;
      s.re = in_real;
      s.im = in_imag;
      if (m_drain > 0) m_drain--;
      else if (m_pend) begin
        if (sink_ready) begin
          m_out = m_pk;
          m_osz = m_psz;
          m_odp = m_pdp;
          m_olen = m_pk.size();
          m_ostart = cyc + 2;
          m_drain = m_olen;
          m_pend = 0;
        end
      end else if (rdy && in_valid) begin
        if (in_sop) begin
          m_cur.delete();
          m_cur.push_back(s);
          m_col = 1;
          m_sz = in_size;
          m_dp = in_dftpts;
        end else if (m_col) begin
          if (m_cur.size() == DEPTH) begin
            m_ovf = 1; m_col = 0; m_cur.delete();
          end else m_cur.push_back(s);
        end
        if (m_col && in_eop) begin
          m_col = 0;
`ifdef MRD_PKTBUF_LEN_CHK_EN
          if (m_cur.size() != int'(m_dp)) m_len = 1;
          else begin
            m_pk = m_cur; m_psz = m_sz; m_pdp = m_dp; m_pend = 1;
          end
`else
          m_pk = m_cur; m_psz = m_sz; m_pdp = m_dp; m_pend = 1;
`endif
        end
      end
    end
  end

  // Literal monitors
  int bcnt = 0, sop_cyc = 0, ovf_cnt = 0, len_cnt = 0;
  int first_re = 0, last_re = 0;

  always @(negedge clk) begin
    int idx;
    if (rst) begin
      chk("rst in_ready", in_ready, 0);
      chk("rst out_valid", out_valid, 0);
      chk("rst sop_eop", {out_sop, out_eop}, 0);
      chk("rst data", {out_real, out_imag}, 0);
      chk("rst size_pts", {out_size, out_dftpts}, 0);
      chk("rst err", {err_ovf, err_len}, 0);
    end else begin
      chk("in_ready", in_ready, !m_pend && m_drain == 0);
      chk("err_ovf", err_ovf, m_ovf);
      chk("err_len", err_len, m_len);
      idx = cyc - m_ostart;
      if (m_olen > 0 && idx >= 0 && idx < m_olen) begin
        chk("out_valid", out_valid, 1);
        chk("out_sop", out_sop, idx == 0);
        chk("out_eop", out_eop, idx == m_olen - 1);
        chk("out_real", out_real, m_out[idx].re);
        chk("out_imag", out_imag, m_out[idx].im);
        chk("out_size", out_size, m_osz);
        chk("out_dftpts", out_dftpts, m_odp);
      end else chk("out_idle", out_valid, 0);
      if (out_valid) begin
        bcnt++;
        if (out_sop) begin
          sop_cyc = cyc;
          first_re = out_real;
        end
        last_re = out_real;
      end
      ovf_cnt += err_ovf;
      len_cnt += err_len;
    end
  end

  int eop_cyc = 0;

  task automatic put(input bit s, input bit e, input int re, input int im);
    in_valid = 1'b1;
    in_sop = s;
    in_eop = e;
    in_real = 18'(re);
    in_imag = 18'(im);
    @(posedge clk);
    #1;
  endtask

  task automatic pkt(input int n, input int base, input bit with_eop);
    for (int i = 0; i < n; i++)
      put(i == 0, with_eop && i == n - 1, base + i, base + i + 1000);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    eop_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_burst(input int target, input int budget);
    int k;
    k = 0;
    while (bcnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("burst wait timeout", int'(bcnt >= target), 1);
  endtask

  int b0, o0, l0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("T0 in_ready after rst", in_ready, 1);
    chk("T0 out_valid", out_valid, 0);
    @(posedge clk); #1;

    // T1: 12-point packet, immediate sink_ready
    sink_ready = 1'b1;
    in_size = 6'd3; in_dftpts = 12'd12;
    b0 = bcnt;
    pkt(12, 1, 1);
    idle(25);
    chk("T1 latency", sop_cyc - eop_cyc, 3);
    chk("T1 count", bcnt - b0, 12);
    chk("T1 first", first_re, 1);
    chk("T1 last", last_re, 12);

    // T2: 1200-point packet held in WAIT
    sink_ready = 1'b0;
    in_size = 6'd40; in_dftpts = 12'd1200;
    b0 = bcnt;
    pkt(1200, 5, 1);
    idle(500);
    chk("T2 held in_ready", in_ready, 0);
    chk("T2 no output", bcnt - b0, 0);
    sink_ready = 1'b1;
    wait_burst(b0 + 1200, 1300);
    idle(5);
    chk("T2 count", bcnt - b0, 1200);
    chk("T2 first", first_re, 5);
    chk("T2 last", last_re, 1204);

    // T3: restart at sample 5, second packet of 24
    in_size = 6'd7; in_dftpts = 12'd24;
    b0 = bcnt; o0 = ovf_cnt; l0 = len_cnt;
    pkt(4, 300, 0);
    pkt(24, 400, 1);
    idle(35);
    chk("T3 count", bcnt - b0, 24);
    chk("T3 first", first_re, 400);
    chk("T3 last", last_re, 423);
    chk("T3 no err", (ovf_cnt - o0) + (len_cnt - l0), 0);

    // T4: overflow on the 2049th sample
    in_dftpts = 12'd0;
    b0 = bcnt; o0 = ovf_cnt;
    pkt(DEPTH + 1, 7, 0);
    @(negedge clk);
    chk("T4 err_ovf pulse", err_ovf, 1);
    chk("T4 in_ready", in_ready, 1);
    idle(10);
    chk("T4 ovf count", ovf_cnt - o0, 1);
    chk("T4 no output", bcnt - b0, 0);

    // T5: dftpts 36, eop at sample 35
    in_dftpts = 12'd36;
    b0 = bcnt; l0 = len_cnt;
    pkt(35, 900, 1);
    idle(45);
`ifdef MRD_PKTBUF_LEN_CHK_EN
    chk("T5 err_len count", len_cnt - l0, 1);
    chk("T5 no output", bcnt - b0, 0);
`else
    chk("T5 no err_len", len_cnt - l0, 0);
    chk("T5 count", bcnt - b0, 35);
`endif

    // T6: reset mid-burst
    in_dftpts = 12'd200;
    b0 = bcnt;
    pkt(200, 2000, 1);
    wait_burst(b0 + 100, 300);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("T6 rst out_valid", out_valid, 0);
    chk("T6 rst in_ready", in_ready, 0);
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("T6 in_ready after rst", in_ready, 1);
    b0 = bcnt;
    idle(20);
    chk("T6 no more output", bcnt - b0, 0);

    // T7: one-sample packet
    in_size = 6'd1; in_dftpts = 12'd1;
    b0 = bcnt;
    pkt(1, 77, 1);
    idle(8);
    chk("T7 count", bcnt - b0, 1);
    chk("T7 value", first_re, 77);
    chk("T7 latency", sop_cyc - eop_cyc, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mrd_sink_pkt_buf.md
# mrd_sink_pkt_buf

Single-packet input buffer in front of the mixed-radix DFT memory top. Absorbs one complete DFT input packet while the memory top is busy, then replays it as a contiguous sop..eop burst once the memory top signals `sink_ready`. Upstream sources can therefore deliver packets without tracking the memory top's stage and source timing. Malformed packets (restarted, overlong, wrong length) are dropped here rather than corrupting the memory top's Sink stage.

## Interface
- `DEPTH`, 2048: buffer capacity in complex samples; must be ≥ largest DFT size (1200).
- `wADDR`, 11: address width, equal to log2(`DEPTH`).
- `wDATA`, 18: width of each real/imag component.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`, `in_sop`, `in_eop`  in  1 each  upstream sample strobe and packet delimiters.
- `in_real`, `in_imag`  in  `wDATA` each  upstream sample.
- `in_size`  in  6  DFT size index; sampled on accepted sop.
- `in_dftpts`  in  12  DFT points; sampled on accepted sop.
- `in_ready`  out  1  high while the buffer can accept samples (IDLE or FILL).
- `sink_ready`  in  1  memory top is idle and will accept a packet.
- `out_valid`, `out_sop`, `out_eop`  out  1 each  replayed packet strobes.
- `out_real`, `out_imag`  out  `wDATA` each  replayed sample.
- `out_size`  out  6  held from sop through eop of the replayed packet.
- `out_dftpts`  out  12  held from sop through eop of the replayed packet.
- `err_ovf`, `err_len`  out  1 each  one-cycle pulse when a packet is dropped.

## Operation
- States:
  - IDLE: `in_ready`=1. An accepted sample (`in_valid`&`in_sop`) is written at address 0. Latch `in_size`/`in_dftpts`, set `wcnt`=1, go to FILL. Samples without sop are ignored.
  - FILL: each `in_valid` writes at address `wcnt`, then `wcnt`++.
    - `in_eop` with valid: go to WAIT, with `len`=`wcnt`+1.
    - `in_sop` with valid: restart. Write at address 0, `wcnt`=1, re-latch size/dftpts, no error flag.
    - Valid sample arriving while `wcnt`==`DEPTH`: drop the packet, pulse `err_ovf`, go to IDLE.
  - WAIT: `in_ready`=0. Go to DRAIN when `sink_ready`=1.
  - DRAIN: `in_ready`=0. Read addresses 0..`len`-1 on consecutive cycles with no gaps; there is no backpressure. After the last read is issued, go to IDLE.
- Buffer is a simple dual-port RAM with one write port and one read port; read latency is 1 cycle, and q is registered once more to the outputs.
- `out_sop` marks the address-0 sample; `out_eop` marks the address `len`-1 sample. `len`==1 asserts both in the same cycle.
- `sink_ready` is ignored outside WAIT. The memory top drops it after sop, which is expected.
- Counters are `wADDR`+1 bits wide so `DEPTH` is representable; there is no wrap-around.

## Timing
- Reset values: state IDLE; `in_ready`=0 while `rst` is high and 1 from the first cycle after release. `out_valid`/`out_sop`/`out_eop`=0, `out_real`/`out_imag`=0, `out_size`=0, `out_dftpts`=0, `err_ovf`/`err_len`=0, counters 0.
- `sink_ready` sampled high in WAIT at edge k: state is DRAIN after k, address 0 is read in cycle k+1, and `out_valid`/`out_sop` are high after edge k+2 (latency 2).
- The burst lasts exactly `len` consecutive `out_valid` cycles. `out_valid` falls the cycle after `out_eop`.
- Earliest re-accept: `in_ready` is high the cycle after the last read is issued, while the final 1–2 outputs are still in flight. Writes and reads in that overlap touch different addresses, or the read precedes the write.
- Simultaneous `in_sop` and `in_eop` in IDLE: a one-sample packet; go directly to WAIT.
- Asserting `rst` mid-DRAIN truncates the burst immediately with no eop. The memory top's overTime recovers from this.

## Configuration
- `MRD_PKTBUF_LEN_CHK_EN` defined: on eop, `len` is compared with the latched `dftpts`. On mismatch, pulse `err_len` the cycle after eop and return to IDLE without draining.
- `MRD_PKTBUF_LEN_CHK_EN` undefined: no comparison; every eop-terminated packet is replayed with its received length, and `err_len` is tied to 0.

## Structure
- `mrd_mem_pkt` package gains `PKTBUF_DEPTH` and `wPKTBUF_ADDR` constants, plus the enum typedef `pktbuf_state_t` {IDLE, FILL, WAIT, DRAIN}.
- One sub-module: `mrd_pktbuf_ram`, a behavioral simple dual-port RAM (`DEPTH` × 2·`wDATA`, registered q) that can be swapped for the vendor RAM IP.

## Test plan
- Sink 12-point packet, values 1..12, `sink_ready`=1 → after eop, `out_sop` 2 cycles after WAIT; 12 contiguous outputs 1..12; `out_eop` on the 12th; `out_dftpts`=12 throughout.
- Hold `sink_ready`=0 for 500 cycles after a 1200-point packet → `in_ready`=0 and no output. Raise `sink_ready` → 1200-sample burst, exact order.
- `in_sop` at sample 5 of a 24-point packet, then 24 samples with eop → only the second packet is replayed; no error pulse.
- 2049 valid samples with no eop (`DEPTH`=2048) → `err_ovf` pulse on the 2049th; no output; `in_ready`=1 next cycle.
- With `MRD_PKTBUF_LEN_CHK_EN`: `dftpts`=36 with eop at sample 35 → `err_len` pulse; no output. Without the macro: 35-sample burst.
- Assert `rst` at burst sample 100 → all outputs 0 while `rst` is high; `in_ready`=0 during reset, 1 the cycle after release.
